wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, max cycles waited for any wb_ack edge; legal range 2..65535.
REQ-002 Parameter RD_SETTLE, default 2, cycles between observed wb_ack rise and wb_data_in capture on reads; legal range 0..15.
REQ-003 Clocking/reset: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock; all logic on posedge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  initiator can accept a command.
REQ-008 cmd_we  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  2  register address: 0 TX data, 1 RX data, 2 frequency divider.
REQ-010 cmd_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_rdata  out  8  read data; 0 for writes and timeouts.
REQ-014 rsp_timeout  out  1  transaction aborted by timeout.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 wb_addr  out  2  bus address.
REQ-017 wb_data_out  out  8  bus write data.
REQ-018 wb_data_in  in  8  bus read data from responder.
REQ-019 wb_we  out  1  bus direction: LOW = write, HIGH = read.
REQ-020 wb_stb  out  1  bus strobe.
REQ-021 wb_clk  out  1  bus cycle qualifier; responder acts on wb_stb and wb_clk both high, releases on wb_clk low.
REQ-022 wb_ack  in  1  responder acknowledge.

Function
REQ-023 All outputs SHALL be registered; states IDLE, REQ, SETTLE, RELEASE, RESP.
REQ-024 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch cmd fields, drive wb_addr=cmd_addr, wb_data_out=cmd_wdata, wb_we=~cmd_we, wb_stb=1, wb_clk=1 next cycle, clear counter, go REQ.
REQ-025 cmd_ready SHALL be 0 in every state except IDLE; commands are never queued.
REQ-026 REQ: on wb_ack=1, writes go RELEASE, reads go SETTLE; wb_addr/wb_data_out/wb_we held stable throughout REQ and SETTLE.
REQ-027 REQ timeout: when counter reaches TIMEOUT_CYCLES-1 with wb_ack=0, drop wb_stb/wb_clk, set rsp_timeout=1, rsp_rdata=0, go RESP.
REQ-028 SETTLE: wait RD_SETTLE cycles (RD_SETTLE=0 captures in the ack-observed cycle), capture wb_data_in into rsp_rdata, go RELEASE.
REQ-029 RELEASE: wb_stb=0, wb_clk=0; on wb_ack=0 go RESP; wb_ack still 1 after TIMEOUT_CYCLES cycles sets rsp_timeout=1, go RESP (captured read data kept).
REQ-030 RESP: rsp_valid=1 with rsp_rdata/rsp_timeout stable until rsp_ready=1; then rsp_valid=0, go IDLE next cycle.
REQ-031 rsp_ready with rsp_valid=0 SHALL be ignored.
REQ-032 Counter SHALL be 16 bits, cleared on each state entry, saturating, never wrapping.
REQ-033 wb_ack already high on entry to REQ counts as acknowledge (level-sensitive).

Reset
REQ-034 Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0, wb_stb=0, wb_clk=0, wb_we=1, wb_addr=0, wb_data_out=0; state IDLE, counter 0.
REQ-035 Reset mid-transaction SHALL drop wb_stb/wb_clk on the next edge and discard the response; no rsp_valid for the aborted command.
REQ-036 cmd_ready SHALL rise the first cycle after reset deasserts.

Verification
REQ-037 Write addr 0 data 0x55, responder acks 1 cycle after stb/clk, drops 1 cycle after clk low -> wb_we=0, wb_data_out=0x55, rsp_valid with rsp_timeout=0, rsp_rdata=0.
REQ-038 Read addr 1, responder acks then presents 0xA7 two cycles later (RD_SETTLE=2) -> wb_we=1, rsp_rdata=0xA7, rsp_timeout=0.
REQ-039 Write addr 2 data 78, wb_ack tied 0, TIMEOUT_CYCLES=16 -> wb_stb falls after 16 REQ cycles, rsp_timeout=1.
REQ-040 wb_ack stuck 1 after read ack -> RELEASE times out, rsp_timeout=1, rsp_rdata holds captured value.
REQ-041 rsp_ready held 0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, new cmd_valid ignored.
REQ-042 Reset asserted in SETTLE -> wb_stb=wb_clk=0 next cycle, no rsp_valid, cmd_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//
// Turns single register commands (read or write, 2-bit address, 8-bit data)
// into one bus handshake with a simple responder, then hands back a single
// response carrying the read data and a timeout flag.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles waited for any wb_ack edge (2..65535)
//   RD_SETTLE       cycles from observed wb_ack to wb_data_in capture (0..15)
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_we (1 = write), cmd_addr,
//                         cmd_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_rdata, rsp_timeout
//   busy                  high whenever the initiator is not idle
//   wb_addr, wb_data_out  bus address / write data
//   wb_we                 bus direction, LOW = write, HIGH = read
//   wb_stb, wb_clk        strobe and cycle qualifier, raised and dropped together
//   wb_data_in, wb_ack    responder read data and acknowledge
// ---------------------------------------------------------------------------
module wb_initiator #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int RD_SETTLE      = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic [1:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_timeout,
   output logic       busy,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   input  logic [7:0] wb_data_in,
   output logic       wb_we,
   output logic       wb_stb,
   output logic       wb_clk,
   input  logic       wb_ack
);

   typedef enum logic [2:0] {IDLE, REQ, SETTLE, RELEASE, RESP} state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST  = 16'(RD_SETTLE - 1);

   state_t      state, next_state;
   logic [15:0] count, count_d;
   logic        cmd_we_q, cmd_we_d;

   logic       cmd_ready_d, busy_d, rsp_valid_d, rsp_timeout_d;
   logic       wb_stb_d, wb_clk_d, wb_we_d;
   logic [7:0] rsp_rdata_d, wb_data_out_d;
   logic [1:0] wb_addr_d;

   // State register: every output is a flop loaded from the values the
   // output logic prepares for the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         cmd_we_q    <= 1'b0;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
         wb_stb      <= 1'b0;
         wb_clk      <= 1'b0;
         wb_we       <= 1'b1;
         wb_addr     <= '0;
         wb_data_out <= '0;
      end else begin
         state       <= next_state;
         count       <= count_d;
         cmd_we_q    <= cmd_we_d;
         cmd_ready   <= cmd_ready_d;
         busy        <= busy_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_timeout <= rsp_timeout_d;
         wb_stb      <= wb_stb_d;
         wb_clk      <= wb_clk_d;
         wb_we       <= wb_we_d;
         wb_addr     <= wb_addr_d;
         wb_data_out <= wb_data_out_d;
      end
   end

   // Next-state logic. The acknowledge is level sensitive, so an ack that is
   // already high on the first REQ cycle is taken immediately. With no
   // settle delay a read skips SETTLE and captures in the ack cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (cmd_valid && cmd_ready) next_state = REQ;
         REQ: begin
            if (wb_ack) begin
               if (cmd_we_q || RD_SETTLE == 0) next_state = RELEASE;
               else                            next_state = SETTLE;
            end else if (count == TIMEOUT_LAST) begin
               next_state = RESP;
            end
         end
         SETTLE:  if (count == SETTLE_LAST) next_state = RELEASE;
         RELEASE: if (!wb_ack || count == TIMEOUT_LAST) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output logic: computes the next value of every registered output from
   // the current state and the transition being taken. The counter restarts
   // on every state change and saturates instead of wrapping.
   always_comb begin
      cmd_ready_d   = (next_state == IDLE);
      busy_d        = (next_state != IDLE);
      cmd_we_d      = cmd_we_q;
      rsp_valid_d   = rsp_valid;
      rsp_rdata_d   = rsp_rdata;
      rsp_timeout_d = rsp_timeout;
      wb_stb_d      = wb_stb;
      wb_clk_d      = wb_clk;
      wb_we_d       = wb_we;
      wb_addr_d     = wb_addr;
      wb_data_out_d = wb_data_out;

      if (next_state != state)   count_d = '0;
      else if (count != 16'hFFFF) count_d = count + 16'd1;
      else                        count_d = count;

      case (state)
         IDLE: begin
            if (next_state == REQ) begin
               cmd_we_d      = cmd_we;
               wb_addr_d     = cmd_addr;
               wb_data_out_d = cmd_wdata;
               wb_we_d       = ~cmd_we;
               wb_stb_d      = 1'b1;
               wb_clk_d      = 1'b1;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b0;
            end
         end
         REQ: begin
            if (next_state == RESP) begin
               wb_stb_d      = 1'b0;
               wb_clk_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else if (next_state == RELEASE) begin
               wb_stb_d = 1'b0;
               wb_clk_d = 1'b0;
               if (!cmd_we_q) rsp_rdata_d = wb_data_in;
            end
         end
         SETTLE: begin
            if (next_state == RELEASE) begin
               wb_stb_d    = 1'b0;
               wb_clk_d    = 1'b0;
               rsp_rdata_d = wb_data_in;
            end
         end
         RELEASE: begin
            if (next_state == RESP) begin
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = wb_ack;
            end
         end
         RESP: begin
            if (next_state == IDLE) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
//
// Drives directed and random commands into wb_initiator while acting as the
// bus responder, and predicts each response (timeout, read data, strobe and
// release durations) from the acknowledge/release delays alone.
// ---------------------------------------------------------------------------
module tb_wb_initiator;

   localparam int TO     = 16;
   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_we;
   logic [1:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [7:0] rsp_rdata;
   logic [1:0] wb_addr;
   logic [7:0] wb_data_out, wb_data_in;
   logic       wb_we, wb_stb, wb_clk, wb_ack;

   int total = 0;
   int bad   = 0;

   wb_initiator #(.TIMEOUT_CYCLES(TO), .RD_SETTLE(SETTLE)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_we      (cmd_we),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .wb_addr     (wb_addr),
      .wb_data_out (wb_data_out),
      .wb_data_in  (wb_data_in),
      .wb_we       (wb_we),
      .wb_stb      (wb_stb),
      .wb_clk      (wb_clk),
      .wb_ack      (wb_ack)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents a command; the caller drops cmd_valid one cycle later.
   task automatic applyStimulus(input logic we, input logic [1:0] addr,
                                input logic [7:0] wdata);
      cmd_we    = we;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
   endtask

   // Runs one complete transaction. ackDelay counts strobe cycles before the
   // responder acks (0 = ack already high), relDelay counts low-strobe cycles
   // before the ack is dropped, hold is how long the response is back-pressured.
   task automatic runTxn(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                         input int ackDelay, input int relDelay,
                         input logic [7:0] rdValue, input int hold);
      int         ackAt, expStb, expLow, stbCnt, lowCnt, waitCnt;
      logic       expTo, got, busOk, holdOk;
      logic [7:0] expRd;

      // Reference model: outcome depends only on how long each ack edge takes.
      ackAt = (ackDelay < 1) ? 1 : ackDelay;
      if (ackAt > TO) begin
         expTo  = 1'b1;
         expRd  = 8'h00;
         expStb = TO;
         expLow = 0;
      end else begin
         expStb = ackAt + (we ? 0 : SETTLE);
         expRd  = we ? 8'h00 : rdValue;
         expTo  = (relDelay > TO);
         expLow = expTo ? TO : relDelay;
      end

      waitCnt = 0;
      while (cmd_ready !== 1'b1 && waitCnt < 5) begin
         @(negedge clk);
         waitCnt++;
      end
      checkOutput("cmd_ready_idle", cmd_ready, 1);

      applyStimulus(we, addr, wdata);
      wb_ack = (ackDelay == 0);
      stbCnt = 0;
      lowCnt = 0;
      got    = 1'b0;
      busOk  = 1'b1;
      for (int c = 0; c < 4 * TO + 40; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         rsp_ready  = 1'($urandom);
         wb_data_in = rdValue ^ 8'($urandom_range(1, 255));
         if (wb_stb === 1'b1) begin
            stbCnt++;
            busOk &= (wb_clk === 1'b1 && wb_addr === addr && wb_data_out === wdata &&
                      wb_we === ~we && cmd_ready === 1'b0 && busy === 1'b1);
            if (stbCnt == ackDelay) wb_ack = 1'b1;
            if (!we && stbCnt == ackAt + SETTLE) wb_data_in = rdValue;
         end else if (stbCnt > 0) begin
            lowCnt++;
            busOk &= (wb_clk === 1'b0 && busy === 1'b1 && cmd_ready === 1'b0);
            if (lowCnt == relDelay) wb_ack = 1'b0;
         end
      end

      checkOutput("rsp_seen", got, 1);
      checkOutput("rsp_timeout", rsp_timeout, expTo);
      checkOutput("rsp_rdata", rsp_rdata, expRd);
      checkOutput("stb_cycles", stbCnt, expStb);
      checkOutput("release_cycles", lowCnt, expLow);
      checkOutput("bus_fields", busOk, 1);

      // Back-pressure the response while offering a command that must be ignored.
      rsp_ready = 1'b0;
      wb_ack    = 1'b0;
      applyStimulus(~we, 2'(addr + 2'd1), ~wdata);
      holdOk = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         holdOk &= (rsp_valid === 1'b1 && rsp_rdata === expRd && rsp_timeout === expTo &&
                    cmd_ready === 1'b0 && wb_stb === 1'b0 && busy === 1'b1);
      end
      checkOutput("rsp_hold", holdOk, 1);

      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("rsp_drop", rsp_valid, 0);
   endtask

   initial begin
      logic ok;

      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_we     = 1'b0;
      cmd_addr   = '0;
      cmd_wdata  = '0;
      rsp_ready  = 1'b0;
      wb_data_in = '0;
      wb_ack     = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset_cmd_ready", cmd_ready, 0);
      checkOutput("reset_wb_we", wb_we, 1);
      checkOutput("reset_strobe", {wb_stb, wb_clk}, 0);
      checkOutput("reset_rsp", {rsp_valid, rsp_timeout, busy, rsp_rdata}, 0);
      checkOutput("reset_bus", {wb_addr, wb_data_out}, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", cmd_ready, 1);

      // Basic write, basic read, timeouts, long back-pressure.
      runTxn(1'b1, 2'd0, 8'h55, 1, 1, 8'h00, 2);
      runTxn(1'b0, 2'd1, 8'h00, 1, 1, 8'hA7, 1);
      runTxn(1'b1, 2'd2, 8'd78, TO + 1, 1, 8'h00, 0);
      runTxn(1'b0, 2'd1, 8'h3C, 3, 1000, 8'hC5, 1);
      runTxn(1'b1, 2'd0, 8'h9A, 2, 2, 8'h00, 10);

      // Timing boundaries and a pre-asserted ack.
      runTxn(1'b1, 2'd2, 8'h11, TO, 1, 8'h00, 0);
      runTxn(1'b0, 2'd0, 8'h22, TO, TO, 8'h5E, 1);
      runTxn(1'b0, 2'd1, 8'h33, 2, TO + 1, 8'h81, 0);
      runTxn(1'b0, 2'd2, 8'h44, 0, 1, 8'hE4, 0);
      runTxn(1'b1, 2'd1, 8'h66, 0, 3, 8'h00, 1);

      // Reset while a read is settling drops the bus and loses the response.
      checkOutput("cmd_ready_pre_abort", cmd_ready, 1);
      applyStimulus(1'b0, 2'd1, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b0;
      wb_ack    = 1'b1;
      @(negedge clk);
      checkOutput("settle_strobe", wb_stb, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_strobe", {wb_stb, wb_clk}, 0);
      checkOutput("abort_rsp", {rsp_valid, busy, cmd_ready}, 0);
      reset  = 1'b0;
      wb_ack = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", cmd_ready, 1);
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         ok &= (rsp_valid === 1'b0);
      end
      checkOutput("abort_no_rsp", ok, 1);

      // Random transactions around the timeout boundaries.
      for (int n = 0; n < 24; n++) begin
         runTxn(1'($urandom), 2'($urandom_range(0, 2)), 8'($urandom),
                int'($urandom_range(0, TO + 2)), int'($urandom_range(1, TO + 2)),
                8'($urandom), int'($urandom_range(0, 4)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
